// File: rtl/param_up_down_counter_pkg.sv
// Shared types and helpers for the parameterised up/down counter.
package udc_pkg;

  localparam int UDC_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    UDC_HOLD = 2'd0,
    UDC_UP   = 2'd1,
    UDC_DOWN = 2'd2
  } udc_dir_e;

  // Next count over a 16-bit container; callers truncate to their own width.
  // cnt never exceeds max_val, so +1 cannot carry past the caller's width.
  function automatic logic [15:0] udc_next_cnt(input logic [15:0] cnt,
                                               input udc_dir_e    dir,
                                               input logic [15:0] max_val,
                                               input logic        sat);
    logic [15:0] r;
    r = cnt;
    case (dir)
      UDC_UP: begin
        if (cnt == max_val) r = sat ? cnt : 16'd0;
        else                r = cnt + 16'd1;
      end
      UDC_DOWN: begin
        if (cnt == 16'd0) r = sat ? cnt : max_val;
        else              r = cnt - 16'd1;
      end
      default: r = cnt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_up_down_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface param_up_down_counter_if
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_DEFAULT_WIDTH
);
  logic             up;
  logic             down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_out;
  logic             rollover_flag;
  logic             underflow_flag;
  logic             at_max;
  logic             at_zero;

  modport master (
    output up, down, clear, load, load_val,
    input  count_out, rollover_flag, underflow_flag, at_max, at_zero
  );

  modport slave (
    input  up, down, clear, load, load_val,
    output count_out, rollover_flag, underflow_flag, at_max, at_zero
  );
endinterface

// File: rtl/param_up_down_counter_next_count.sv
// Direction decode and next-count/event computation (purely combinational).
// PARAM_UP_DOWN_COUNTER_SAT_EN selects saturate-at-limits instead of wrap.
module udc_next_count
  import udc_pkg::*;
#(
  parameter int               WIDTH   = UDC_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] nxt_count,
  output logic             roll_evt,
  output logic             undr_evt
);
`ifdef PARAM_UP_DOWN_COUNTER_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  udc_dir_e dir;

  // Opposing requests cancel out to a hold.
  always_comb begin
    dir = UDC_HOLD;
    if (up && !down)      dir = UDC_UP;
    else if (down && !up) dir = UDC_DOWN;
  end

  assign nxt_count = WIDTH'(udc_next_cnt(16'(count), dir, 16'(MAX_VAL), SAT));
  assign roll_evt  = (dir == UDC_UP)   && (count == MAX_VAL);
  assign undr_evt  = (dir == UDC_DOWN) && (count == '0);

endmodule

// File: rtl/param_up_down_counter.sv
// Up/down counter with terminal count, load/clear and one-cycle wrap flags.
// Define PARAM_UP_DOWN_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module param_up_down_counter
  import udc_pkg::*;
#(
  parameter int WIDTH        = UDC_DEFAULT_WIDTH,
  parameter int ROLLOVER_VAL = (1 << WIDTH) - 1
) (
  input logic                     clk,
  input logic                     rst,
  param_up_down_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(ROLLOVER_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic             undr_q, undr_d;
  logic [WIDTH-1:0] step_cnt;
  logic             step_roll, step_undr;

  udc_next_count #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX)
  ) u_next (
    .count     (count_q),
    .up        (bus.up),
    .down      (bus.down),
    .nxt_count (step_cnt),
    .roll_evt  (step_roll),
    .undr_evt  (step_undr)
  );

  // clear > load > up/down; flags only come from the count path.
  always_comb begin
    count_d = count_q;
    roll_d  = 1'b0;
    undr_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
    end else begin
      count_d = step_cnt;
      roll_d  = step_roll;
      undr_d  = step_undr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      undr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      undr_q  <= undr_d;
    end
  end

  assign bus.count_out      = count_q;
  assign bus.rollover_flag  = roll_q;
  assign bus.underflow_flag = undr_q;
  assign bus.at_max         = (count_q == MAX);
  assign bus.at_zero        = (count_q == '0);

endmodule

// File: doc/param_up_down_counter.md
PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 SHALL have parameter ROLLOVER_VAL, default 2**WIDTH-1: terminal count, legal range 1..2**WIDTH-1.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port up, input, 1: count-up request.
REQ-006 SHALL have port down, input, 1: count-down request.
REQ-007 SHALL have port clear, input, 1: synchronous clear to 0.
REQ-008 SHALL have port load, input, 1: synchronous load of load_val.
REQ-009 SHALL have port load_val, input, WIDTH: value to load.
REQ-010 SHALL have port count_out, output, WIDTH: registered count.
REQ-011 SHALL have port rollover_flag, output, 1: registered one-cycle pulse on an up wrap or up saturation event.
REQ-012 SHALL have port underflow_flag, output, 1: registered one-cycle pulse on a down wrap or down saturation event.
REQ-013 SHALL have port at_max, output, 1: combinational, count_out == ROLLOVER_VAL.
REQ-014 SHALL have port at_zero, output, 1: combinational, count_out == 0.

Function
REQ-015 SHALL update count_out once per rising clk edge, with priority rst > clear > load > up/down.
REQ-016 up=1, down=0: count_out SHALL become count_out+1, or 0 when count_out == ROLLOVER_VAL, with rollover_flag=1 for the next cycle.
REQ-017 down=1, up=0: count_out SHALL become count_out-1, or ROLLOVER_VAL when count_out == 0, with underflow_flag=1 for the next cycle.
REQ-018 up=down=1 or up=down=0: count_out SHALL hold, and both flags SHALL be 0 next cycle.
REQ-019 load: count_out SHALL take min(load_val, ROLLOVER_VAL); flags SHALL be 0 next cycle.
REQ-020 clear: count_out SHALL become 0; flags SHALL be 0 next cycle; clear overrides a simultaneous load/up/down.
REQ-021 Flags SHALL be pulses: high for exactly one cycle per event, and high again on consecutive cycles only if the event repeats.
REQ-022 Latency: a request in cycle N SHALL be visible on count_out and the flags in cycle N+1.
REQ-023 The count SHALL never exceed ROLLOVER_VAL, and all arithmetic SHALL be WIDTH bits with no carry-out leakage.

Reset
REQ-024 rst=1 SHALL force count_out=0, rollover_flag=0 and underflow_flag=0 immediately, independent of clk.
REQ-025 rst asserted mid-count SHALL abort the pending update; the first edge after deassertion SHALL act on the inputs present at that edge.

Configuration
REQ-026 Macro PARAM_UP_DOWN_COUNTER_SAT_EN defined: the block SHALL saturate instead of wrapping (up at ROLLOVER_VAL holds; down at 0 holds), and the corresponding flag SHALL still pulse on each blocked request.
REQ-027 Macro undefined: the block SHALL wrap as in REQ-016/REQ-017, and no saturation logic SHALL be synthesised.

Structure
REQ-028 Package udc_pkg SHALL hold typedef udc_dir_e {UDC_HOLD, UDC_UP, UDC_DOWN}, the default-width constant, and a next-count function shared with the bench model.
REQ-029 One combinational sub-module udc_next_count SHALL decode direction and compute the next count and event bits; the top level SHALL hold the registers, priority logic and flags.

Verification
REQ-030 WIDTH=4, ROLLOVER_VAL=9, wrap build: 10 up pulses from 0 -> count reaches 9 then 0, rollover_flag high exactly 1 cycle, on the cycle count==0.
REQ-031 Wrap build: count=0, down=1 -> count=9, underflow_flag pulse, at_max=1.
REQ-032 up=down=1 at count 5 for 3 cycles -> count stays 5, flags 0.
REQ-033 load=1, load_val=15, ROLLOVER_VAL=9 -> count=9; load together with clear -> count=0.
REQ-034 SAT build: count=9, up=1 for 3 cycles -> count stays 9, rollover_flag high all 3 cycles; count=0, down=1 -> stays 0, underflow_flag high.
REQ-035 rst pulsed asynchronously mid-cycle at count 7 -> count_out=0 and flags=0 before the next edge; counting resumes from 0 after release.
